// File: rtl/mux_4way_1_pkg.sv
// mux_4way_1_pkg: shared constants for the 4-way multiplexer.
//   SEL_A..SEL_D  : select codes for inputs a, b, c, d
//   MUX_WIDTH_DEF : default data width
package mux_4way_1_pkg;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    localparam int MUX_WIDTH_DEF = 1;

endpackage : mux_4way_1_pkg

// File: rtl/mux_4way_1_if.sv
// mux_4way_1_if: bundles the data/select bus of mux_4way_1.
//   a, b, c, d : data inputs (WIDTH bits)
//   sel        : 2-bit select
//   out        : selected data (WIDTH bits)
// master drives data/select and observes out; slave is the mux side.
interface mux_4way_1_if
    import mux_4way_1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;

    modport master (output a, output b, output c, output d, output sel, input out);
    modport slave  (input a, input b, input c, input d, input sel, output out);
endinterface : mux_4way_1_if

// File: rtl/mux_2way_1.sv
// mux_2way_1: 2-to-1 multiplexer, leaf cell of the 4-way tree.
//   a   : data selected when sel=0
//   b   : data selected when sel=1
//   sel : 1-bit select
//   out : selected data
// An unknown sel drives an unknown out in simulation only; in synthesis the
// default branch is a don't-care and adds no logic.
module mux_2way_1
    import mux_4way_1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel
);

    // Select between the two inputs.
    always_comb begin
        out = a;
        case (sel)
            1'b0:    out = a;
            1'b1:    out = b;
            default: out = {WIDTH{1'bx}};
        endcase
    end

endmodule : mux_2way_1

// File: rtl/mux_4way_1.sv
// mux_4way_1: 4-to-1 multiplexer built as a tree of three mux_2way_1 cells.
//   clk   : rising-edge clock (used only with MUX_4WAY_1_REG_OUT_EN)
//   reset : synchronous active-high reset (used only with MUX_4WAY_1_REG_OUT_EN)
//   out   : selected input (WIDTH bits)
//   a..d  : data inputs for sel = 0..3
//   sel   : 2-bit unsigned select
// Build option: define MUX_4WAY_1_REG_OUT_EN to register out (1-cycle
// latency, reset clears it to zero). Without it the block is purely
// combinational and clk/reset have no effect.
module mux_4way_1
    import mux_4way_1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel
);

    logic [WIDTH-1:0] low_s;   // a or b, chosen by sel[0]
    logic [WIDTH-1:0] high_s;  // c or d, chosen by sel[0]
    logic [WIDTH-1:0] mux_s;   // final tree output, chosen by sel[1]

    mux_2way_1 #(.WIDTH(WIDTH)) u_mux_low (
        .out (low_s),
        .a   (a),
        .b   (b),
        .sel (sel[0])
    );

    mux_2way_1 #(.WIDTH(WIDTH)) u_mux_high (
        .out (high_s),
        .a   (c),
        .b   (d),
        .sel (sel[0])
    );

    mux_2way_1 #(.WIDTH(WIDTH)) u_mux_root (
        .out (mux_s),
        .a   (low_s),
        .b   (high_s),
        .sel (sel[1])
    );

`ifdef MUX_4WAY_1_REG_OUT_EN
    logic [WIDTH-1:0] out_r;

    // Output register; reset wins over capture so no stale data survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r <= {WIDTH{1'b0}};
        end else begin
            out_r <= mux_s;
        end
    end

    assign out = out_r;
`else
    // clk and reset are kept only so both builds share one port list.
    logic unused_ports_s;
    assign unused_ports_s = ^{clk, reset};

    assign out = mux_s;
`endif

endmodule : mux_4way_1

// File: tb/tb_mux_4way_1.sv
// tb_mux_4way_1: randomized scoreboard bench for mux_4way_1 (WIDTH=1 and
// WIDTH=8 instances driven in lockstep). Each driven cycle pushes the expected
// outputs; a monitor pops them when the outputs are due. Works for both the
// combinational and the MUX_4WAY_1_REG_OUT_EN builds.
`timescale 1ns/1ps
module tb_mux_4way_1;

    typedef struct {
        logic [7:0] exp8;
        logic       exp1;
    } item_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    item_t q[$];
    int    checks = 0;
    int    passes = 0;
    logic  driving_done = 1'b0;

    mux_4way_1_if #(.WIDTH(1)) if1 ();
    mux_4way_1_if #(.WIDTH(8)) if8 ();

    mux_4way_1 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .out(if1.out),
        .a(if1.a), .b(if1.b), .c(if1.c), .d(if1.d), .sel(if1.sel)
    );

    mux_4way_1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .out(if8.out),
        .a(if8.a), .b(if8.b), .c(if8.c), .d(if8.d), .sel(if8.sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus on both instances and record what the
    // outputs must become.
    task automatic drive(input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] vc, input logic [7:0] vd,
                         input logic [1:0] vs, input logic vr);
        logic [7:0] ins [4];
        item_t      it;
        @(negedge clk);
        if8.a = va; if8.b = vb; if8.c = vc; if8.d = vd; if8.sel = vs;
        if1.a = va[0]; if1.b = vb[0]; if1.c = vc[0]; if1.d = vd[0]; if1.sel = vs;
        reset = vr;
        ins = '{va, vb, vc, vd};
        it.exp8 = ins[vs];
`ifdef MUX_4WAY_1_REG_OUT_EN
        if (vr) it.exp8 = 8'h00;
`endif
        it.exp1 = it.exp8[0];
        q.push_back(it);
    endtask

    // Monitor: compare each due output against the scoreboard.
    initial begin : monitor
        item_t it;
`ifdef MUX_4WAY_1_REG_OUT_EN
        item_t last;
        logic  have_last = 1'b0;
        fork
            forever begin
                @(posedge clk);
                #1;
                if (q.size() > 0) begin
                    it = q.pop_front();
                    check("out_w8", if8.out, it.exp8);
                    check("out_w1", {7'd0, if1.out}, {7'd0, it.exp1});
                    last = it;
                    have_last = 1'b1;
                end
            end
            forever begin
                // Inputs changed at this negedge; the register must not follow.
                @(negedge clk);
                #2;
                if (have_last && !driving_done) begin
                    check("hold_w8", if8.out, last.exp8);
                end
            end
        join
`else
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                it = q.pop_front();
                check("out_w8", if8.out, it.exp8);
                check("out_w1", {7'd0, if1.out}, {7'd0, it.exp1});
            end
        end
`endif
    end

    initial begin : stimulus
        logic [3:0]  n;
        logic [31:0] r;
        logic [7:0]  ra, rb, rc, rd;
        int          waited;

        if8.a = 8'h00; if8.b = 8'h00; if8.c = 8'h00; if8.d = 8'h00; if8.sel = 2'd0;
        if1.a = 1'b0;  if1.b = 1'b0;  if1.c = 1'b0;  if1.d = 1'b0;  if1.sel = 2'd0;

        // Reset for two edges, then a=1/sel=0 is loaded on the first free edge.
        drive(8'hFF, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        drive(8'hFF, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        drive(8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
        drive(8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
        // Mid-stream reset with the selected input still 1.
        drive(8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        drive(8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);

        // Exhaustive sweep of the bit-0 lanes; upper lanes random.
        for (int v = 0; v < 16; v++) begin
            n = v[3:0];
            for (int s = 0; s < 4; s++) begin
                r = $urandom;
                drive({r[6:0], n[0]}, {r[13:7], n[1]}, {r[20:14], n[2]},
                      {r[27:21], n[3]}, s[1:0], 1'b0);
            end
        end

        // Distinct wide patterns.
        drive(8'h11, 8'h22, 8'h44, 8'h88, 2'd0, 1'b0);
        drive(8'h11, 8'h22, 8'h44, 8'h88, 2'd1, 1'b0);
        drive(8'h11, 8'h22, 8'h44, 8'h88, 2'd2, 1'b0);
        drive(8'h11, 8'h22, 8'h44, 8'h88, 2'd3, 1'b0);

        // Isolation: sel=2, c=1, unselected inputs toggle, then c toggles.
        drive(8'h00, 8'h00, 8'h01, 8'h00, 2'd2, 1'b0);
        drive(8'hFF, 8'h00, 8'h01, 8'h00, 2'd2, 1'b0);
        drive(8'hFF, 8'hFF, 8'h01, 8'h00, 2'd2, 1'b0);
        drive(8'hFF, 8'hFF, 8'h01, 8'hFF, 2'd2, 1'b0);
        drive(8'h00, 8'h00, 8'h01, 8'h00, 2'd2, 1'b0);
        drive(8'h00, 8'h00, 8'h00, 8'h00, 2'd2, 1'b0);
        drive(8'h00, 8'h00, 8'h01, 8'h00, 2'd2, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 80; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            drive(ra, rb, rc, rd, 2'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0));
        end

        driving_done = 1'b1;
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        checks++;
        if (q.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL drain: %0d items left, expected 0", q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_mux_4way_1
